// File: rtl/moore_seq_pkg.sv
// Shared types, constants and the longest-prefix helper for the serial
// sequence detector.
package moore_seq_pkg;

    // State register width: holds 0..7 matched prefix bits.
    localparam int S_W = 3;

    // Saturation value of the 4-bit match counter.
    localparam int CNT_MAX = 15;

    // Width of the zero-extended history and left-aligned pattern buses.
    localparam int EXT_W = 8;

    typedef logic [S_W-1:0] state_t;

    // Largest k <= window for which the newest k stream bits (LSBs of
    // hist_ext) equal the first k pattern bits. The pattern is passed
    // left-aligned, so its first bit sits at bit EXT_W-1.
    // The result is 0 when no prefix fits.
    function automatic state_t prefix_match(
        input logic [EXT_W-1:0] hist_ext,
        input logic [EXT_W-1:0] pat,
        input logic [3:0]       window
    );
        state_t           k_best;
        logic [EXT_W-1:0] mask;
        k_best = '0;
        mask   = '0;
        for (int k = 1; k < EXT_W; k++) begin
            mask = EXT_W'((9'd1 << k) - 9'd1);
            if ((4'(k) <= window) &&
                ((hist_ext & mask) == ((pat >> (EXT_W - k)) & mask))) begin
                k_best = state_t'(k);
            end
        end
        return k_best;
    endfunction

endpackage

// File: rtl/moore_seq_detector_next_state.sv
// Combinational next-state search.
// Picks the longest pattern prefix that ends the stream, which now
// includes the incoming bit. The search is bounded by the window that the
// overlap mode allows.
module moore_next_state
    import moore_seq_pkg::*;
#(
    parameter int PAT_LEN = 4
) (
    input  state_t             s,
    input  logic [PAT_LEN-2:0] hist_tail,
    input  logic               din,
    input  logic [PAT_LEN-1:0] pat,
    input  logic               overlap,
    output state_t             next_s
);

    localparam state_t ACCEPT = state_t'(PAT_LEN);

    logic [EXT_W-1:0] hist_ext;
    logic [EXT_W-1:0] pat_ext;
    logic [3:0]       window;

    assign hist_ext = {{(EXT_W - PAT_LEN){1'b0}}, hist_tail, din};
    assign pat_ext  = {pat, {(EXT_W - PAT_LEN){1'b0}}};

    // Search window: a non-overlapping restart from ACCEPT may only reuse the new bit.
    always_comb begin
        window = 4'd1;
        if (s == ACCEPT) begin
            window = overlap ? 4'(PAT_LEN) : 4'd1;
        end else begin
            window = 4'(s) + 4'd1;
        end
    end

    assign next_s = prefix_match(hist_ext, pat_ext, window);

endmodule

// File: rtl/moore_seq_detector.sv
// Runtime-loadable Moore sequence detector with a saturating match counter.
// It uses the standard tt_um pin set.
// match, s and count are all taken straight from registers.
module moore_seq_detector
    import moore_seq_pkg::*;
#(
    parameter int                 PAT_LEN = 4,
    parameter int                 CNT_W   = 4,
    parameter logic [PAT_LEN-1:0] PAT_RST = 4'b1011
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam state_t           ACCEPT  = state_t'(PAT_LEN);
    localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(CNT_MAX);

    logic din;
    logic din_valid;
    logic overlap;
    logic load;
    logic clr_cnt;

    assign din       = ui_in[0];
    assign din_valid = ui_in[1];
    assign overlap   = ui_in[2];
    assign load      = ui_in[3];
    assign clr_cnt   = ui_in[4];

    logic [PAT_LEN-1:0] pat_reg,   pat_next;
    logic [PAT_LEN-1:0] hist_reg,  hist_next;
    state_t             s_reg,     s_next;
    logic [CNT_W-1:0]   count_reg, count_next;
    state_t             search_s;
    logic               match;

    moore_next_state #(
        .PAT_LEN (PAT_LEN)
    ) u_next_state (
        .s         (s_reg),
        .hist_tail (hist_reg[PAT_LEN-2:0]),
        .din       (din),
        .pat       (pat_reg),
        .overlap   (overlap),
        .next_s    (search_s)
    );

    // Next-value logic.
    // load beats a sample in the same cycle. clr_cnt beats a counter
    // increment. Nothing moves while ena is low.
    always_comb begin
        pat_next   = pat_reg;
        hist_next  = hist_reg;
        s_next     = s_reg;
        count_next = count_reg;
        if (ena) begin
            if (load) begin
                pat_next  = uio_in[PAT_LEN-1:0];
                hist_next = '0;
                s_next    = '0;
            end else if (din_valid) begin
                hist_next = {hist_reg[PAT_LEN-2:0], din};
                s_next    = search_s;
            end

            if (clr_cnt) begin
                count_next = '0;
            end else if (!load && din_valid && (search_s == ACCEPT) &&
                         (count_reg != CNT_TOP)) begin
                count_next = count_reg + 1'b1;
            end
        end
    end

    // State registers: an asynchronous clear also restores the reset pattern.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pat_reg   <= PAT_RST;
            hist_reg  <= '0;
            s_reg     <= '0;
            count_reg <= '0;
        end else begin
            pat_reg   <= pat_next;
            hist_reg  <= hist_next;
            s_reg     <= s_next;
            count_reg <= count_next;
        end
    end

    assign match   = (s_reg == ACCEPT);
    assign uo_out  = {count_reg, s_reg, match};
    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;

    // Pins and history bits that the logic does not read.
    logic unused_bits;
    assign unused_bits = &{1'b0, ui_in[7:5], uio_in[7:PAT_LEN], hist_reg[PAT_LEN-1]};

endmodule

// File: tb/tb_moore_seq_detector.sv
// Directed bench for moore_seq_detector (PAT_LEN=4, CNT_W=4).
// Expected uo_out values are worked out by hand as {count, s, match}.
module tb_moore_seq_detector;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    wire  [7:0] uo_out;
    wire  [7:0] uio_out;
    wire  [7:0] uio_oe;

    int  n_checks = 0;
    int  n_pass   = 0;
    bit  ovl      = 1'b1;

    moore_seq_detector #(
        .PAT_LEN (4),
        .CNT_W   (4),
        .PAT_RST (4'b1011)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    // One clock of stimulus, driven at the falling edge and observed 1ns after the rising edge.
    task automatic step(input bit d, input bit v, input bit ld, input bit clr,
                        input logic [7:0] pv, input bit en);
        @(negedge clk);
        ena    = en;
        ui_in  = {3'b000, clr, ld, ovl, v, d};
        uio_in = pv;
        @(posedge clk);
        #1;
        $display("txn ena=%0d din=%0d valid=%0d load=%0d clr=%0d ovl=%0d -> uo_out=%h",
                 en, d, v, ld, clr, ovl, uo_out);
        ui_in  = {5'b00000, ovl, 2'b00};
        ena    = 1'b1;
    endtask

    task automatic smp(input bit d);
        step(d, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    endtask

    task automatic load_pat(input logic [7:0] pv);
        step(1'b0, 1'b0, 1'b1, 1'b1, pv, 1'b1);
    endtask

    initial begin
        logic [6:0] stream;
        logic [7:0] exp_ov [7];
        logic [7:0] exp_no [7];
        logic [7:0] exp_so [5];
        logic [7:0] exp_sn [5];
        stream = 7'b1011011;
        exp_ov = '{8'h02, 8'h04, 8'h06, 8'h19, 8'h14, 8'h16, 8'h29};
        exp_no = '{8'h02, 8'h04, 8'h06, 8'h19, 8'h10, 8'h12, 8'h12};
        exp_so = '{8'h02, 8'h04, 8'h06, 8'h19, 8'h29};
        exp_sn = '{8'h02, 8'h04, 8'h06, 8'h19, 8'h12};

        // Reset held with ena high.
        rst_n = 1'b0; ena = 1'b1; ui_in = 8'h04; uio_in = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("reset_uo_out", uo_out, 8'h00);
        check("reset_uio_oe", uio_oe, 8'h00);
        check("reset_uio_out", uio_out, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        smp(1'b1); smp(1'b0); smp(1'b1);
        check("reset_after_101", uo_out, 8'h06);
        smp(1'b1);
        check("reset_first_match", uo_out, 8'h19);

        // Overlapping detection of 1011 in 1011011.
        ovl = 1'b1;
        load_pat(8'h0B);
        check("ov_after_load", uo_out, 8'h00);
        for (int i = 0; i < 7; i++) begin
            smp(stream[6-i]);
            check($sformatf("ov_sample%0d", i + 1), uo_out, exp_ov[i]);
        end

        // Non-overlapping detection of the same stream.
        ovl = 1'b0;
        load_pat(8'h0B);
        for (int i = 0; i < 7; i++) begin
            smp(stream[6-i]);
            check($sformatf("nov_sample%0d", i + 1), uo_out, exp_no[i]);
        end

        // Self-overlapping pattern 1111.
        ovl = 1'b1;
        load_pat(8'h0F);
        for (int i = 0; i < 5; i++) begin
            smp(1'b1);
            check($sformatf("self_ov_sample%0d", i + 1), uo_out, exp_so[i]);
        end
        ovl = 1'b0;
        load_pat(8'h0F);
        for (int i = 0; i < 5; i++) begin
            smp(1'b1);
            check($sformatf("self_nov_sample%0d", i + 1), uo_out, exp_sn[i]);
        end

        // 23 ones against 1111 in overlap mode give 20 matches; the counter saturates at 15.
        ovl = 1'b1;
        load_pat(8'h0F);
        for (int i = 0; i < 23; i++) smp(1'b1);
        check("saturated", uo_out, 8'hF9);
        step(1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 1'b1);
        check("clr_beats_increment", uo_out, 8'h09);

        // A load mid-sequence drops the sample in the same cycle.
        load_pat(8'h0B);
        smp(1'b1); smp(1'b0); smp(1'b1);
        check("mid_before_load", uo_out, 8'h06);
        step(1'b1, 1'b1, 1'b1, 1'b0, 8'h03, 1'b1);
        check("mid_load_ignores_sample", uo_out, 8'h00);
        smp(1'b0); smp(1'b0); smp(1'b1);
        check("pat0011_s3", uo_out, 8'h06);

        // While ena is low, toggling samples, load and clear have no effect.
        for (int i = 0; i < 5; i++) begin
            step(i[0], 1'b1, (i == 2), (i == 3), 8'hFF, 1'b0);
        end
        check("ena_low_frozen", uo_out, 8'h06);
        smp(1'b1);
        check("ena_resume_match", uo_out, 8'h19);

        // An asynchronous reset in mid-cycle clears outputs at once and restores pattern 1011.
        smp(1'b0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("async_reset_immediate", uo_out, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        smp(1'b1); smp(1'b0); smp(1'b1); smp(1'b1);
        check("pat_restored_match", uo_out, 8'h19);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/moore_seq_detector.md
# moore_seq_detector

Parametrised Moore-style serial sequence detector, packaged as a TinyTapeout user project with the standard `tt_um` pin set.
- The detection pattern is runtime-loadable, up to `PAT_LEN` bits long.
- Overlapping or non-overlapping detection is selectable per cycle.
- Prefix fallback follows KMP rules.
- Detected matches are counted by a saturating counter.

It is the generalised successor to the fixed-pattern Moore machine.

## Interface
Parameters:
- `PAT_LEN`, default 4: pattern length in bits. Legal range 2..7.
- `CNT_W`, default 4: match counter width. Fixed at 4 by the `uo_out` mapping.
- `PAT_RST`, default 4'b1011: pattern value loaded at reset.

Ports:
- `clk`  in  1: system clock. Single clock domain.
- `rst_n`  in  1: reset, asynchronous assert, active-low.
- `ena`  in  1: design enable. While low, all state is held and all strobes are ignored.
- `ui_in`  in  8:
  - [0] `din`: serial data bit.
  - [1] `din_valid`: sample strobe.
  - [2] `overlap`: 1 = overlapping, 0 = non-overlapping.
  - [3] `load`: pattern load strobe.
  - [4] `clr_cnt`: counter clear.
  - [7:5] unused.
- `uio_in`  in  8: pattern value, bits [PAT_LEN-1:0], captured on `load`. The MSB is compared first.
- `uo_out`  out  8:
  - [0] `match`: high when s == PAT_LEN.
  - [3:1] `s`: state.
  - [7:4] `count`: match count.
- `uio_out`  out  8: tied 0.
- `uio_oe`  out  8: tied 0 (all bidirectionals are inputs).

## Operation
- Registers:
  - `pat[PAT_LEN-1:0]`
  - `hist[PAT_LEN-1:0]`: last received bits, newest in the LSB.
  - `s[2:0]`: 0..PAT_LEN, the number of pattern-prefix bits currently matched.
  - `count[CNT_W-1:0]`
- Reset values: `pat` = PAT_RST, `hist` = 0, `s` = 0, `count` = 0. All outputs are 0 during and after reset.
- Per-cycle priority, evaluated only when `ena` = 1:
  1. `load`: `pat` <= `uio_in[PAT_LEN-1:0]`, `s` <= 0, `hist` <= 0. Any sample in the same cycle is dropped.
  2. Otherwise, if `din_valid`: `hist` <= {`hist`[PAT_LEN-2:0], `din`}, and `s` <= next state.
- Next-state rule, evaluated on the new stream ending in `din`:
  - Window W:
    - If s == PAT_LEN and `overlap` = 0, W = 1.
    - Otherwise W = min(s+1, PAT_LEN).
  - Next s = the largest k ≤ W such that the last k stream bits equal `pat`[PAT_LEN-1 -: k]. If no such k exists, next s = 0.
- Moore output: `match` is a pure function of `s` and has no combinational path from `ui_in`.
- Counter:
  - Increments on every valid sample whose next s == PAT_LEN. This includes ACCEPT→ACCEPT transitions in overlap mode.
  - Saturates at 2^CNT_W−1; it does not wrap.
  - `clr_cnt` sets `count` to 0 and wins over a same-cycle increment.
  - `clr_cnt` is independent of `load`.
- `overlap` may change at any cycle. It is sampled only on the transition out of ACCEPT.

## Timing
- Latency: the sample completing the pattern at edge N makes `match` = 1 and `count`+1 visible after edge N.
- `match` stays high until the next valid sample or `load`.
- `din_valid` low leaves `s`, `hist`, and `match` unchanged, for any number of cycles.
- When `ena` falls mid-sequence, progress is frozen. It resumes exactly from the same state when `ena` returns.
- Asserting `rst_n` mid-sequence clears everything immediately (asynchronously), including restoring `pat` to PAT_RST.
- Back-to-back valid samples are accepted every cycle; there is no stall.

## Structure
- Package `moore_seq_pkg`:
  - `localparam` `S_W` = 3.
  - `CNT_MAX`.
  - Typedef `state_t` (logic [S_W-1:0]).
  - Function `prefix_match(hist_ext, pat, window)`, which returns k.
- Sub-module `moore_next_state`: combinational longest-prefix search over k = PAT_LEN..1. It is instantiated once by the top.
- Top `moore_seq_detector`: registers, priority logic, saturating counter, and pin mapping.

## Test plan
All cases use PAT_LEN = 4 and CNT_W = 4. Each sample is one `din_valid` cycle.
- **Reset:** hold `rst_n` = 0 with `ena` = 1 → `uo_out` = 0x00 and `uio_oe` = 0x00. Release, then feed 1,0,1,1 with `overlap` = 1 → `match` after the 4th sample and `uo_out` = 0x19.
- **Overlap:** `overlap` = 1, stream 1011011.
  - `match` pulses after samples 4 and 7.
  - `s` after sample 5 = 2.
  - Final `count` = 2.
- **Non-overlap:** `overlap` = 0, stream 1011011.
  - Single match after sample 4.
  - `s` after samples 5, 6, 7 = 0, 1, 1.
  - Final `count` = 1.
- **Self-overlapping pattern:** load `uio_in` = 0x0F, then send five 1s.
  - With `overlap` = 1: `count` = 2, `s` stays at 4.
  - With `overlap` = 0: `count` = 1, `s` = 1 after the 5th sample.
- **Saturation and clear:** drive 20 matches → `count` = 15. Then `clr_cnt` in the same cycle as a completing sample → `match` = 1 and `count` = 0.
- **Load mid-sequence and ena gating:**
  - After 1,0,1, assert `load` with `uio_in` = 0x03 and `din_valid` = 1 → `s` = 0 and the sample is ignored.
  - Then 0,0,1 → `s` = 3. Drop `ena` for 5 cycles with samples toggling → `s` = 3.
  - Restore `ena`, send 1 → `match` = 1.
